dgs_fault_sequencer: RTL

//  Upstream feeder for the diagnostic blink driver. Latches fault events into sticky flags and walks active faults round-robin.
//  For each fault it drives a per-period pulse mask: fault i -> (i+2) pulses; idle heartbeat -> 1 pulse.
//  Its period timer runs in lock-step with the blink driver: same FREQ_HZ/PERIOD_US, same CLK/RSTn.

---
 rtl/dgs_pkg.sv | 31 +++
 rtl/dgs_fault_sequencer_rr_pick.sv | 29 ++
 rtl/dgs_fault_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dgs_pkg.sv
// Shared definitions for the diagnostic sequencer and the blink driver.
// Both sides derive frame timing from these helpers, so their period counters agree.
package dgs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } dgs_state_e;

  function automatic int unsigned period_cycles(input int unsigned freq_hz,
                                                input int unsigned period_us);
    return (freq_hz / 32'd1_000_000) * period_us;
  endfunction

  function automatic int unsigned pulse_cycles(input int unsigned freq_hz,
                                               input int unsigned pulse_us);
    return (freq_hz / 32'd1_000_000) * pulse_us;
  endfunction

  function automatic int unsigned quant_cnt(input int unsigned period_us,
                                            input int unsigned pulse_us);
    return (period_us / pulse_us) / 32'd2;
  endfunction

  // Fault idx i blinks (i+2) pulses: the low (i+2) slots are set.
  function automatic logic [31:0] code_mask(input int unsigned idx);
    return (32'd1 << (idx + 32'd2)) - 32'd1;
  endfunction

endpackage

// File: rtl/dgs_fault_sequencer_rr_pick.sv
// Combinational round-robin finder: first set bit strictly after i_start, wrapping,
// so i_start itself is only chosen when it is the sole set bit.
module dgs_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_vec,
  input  logic [IDX_W-1:0] i_start,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  logic [IDX_W-1:0] w_pos;

  // Scan from the farthest offset down so the nearest hit is the one that sticks.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_pos   = '0;
    for (int k = N; k >= 1; k--) begin
      w_pos = IDX_W'((int'(i_start) + k) % N);
      if (i_vec[w_pos]) begin
        o_idx   = w_pos;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dgs_fault_sequencer.sv
// Latches fault events into sticky flags and presents one blink code per frame,
// walking active faults round-robin with a blank frame between codes.
module dgs_fault_sequencer
  import dgs_pkg::*;
#(
  parameter int unsigned FREQ_HZ   = 100_000_000,
  parameter int unsigned PERIOD_US = 1_000_000,
  parameter int unsigned PULSE_US  = 100_000,
  parameter int unsigned N_FAULTS  = 4,
  parameter int unsigned REPEAT    = 3,
  parameter logic [31:0] IDLE_MASK = 32'h0000_0001,
  localparam int unsigned QUANT_CNT = quant_cnt(PERIOD_US, PULSE_US),
  localparam int IDX_W = (N_FAULTS > 1) ? $clog2(N_FAULTS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_FAULTS-1:0]  i_fault,
  input  logic                 i_clr,
  output logic [QUANT_CNT-1:0] o_mask,
  output logic                 o_active,
  output logic [IDX_W-1:0]     o_cur_idx,
  output logic [N_FAULTS-1:0]  o_sticky
);

  // state   | meaning
  // IDLE    | no fault latched, heartbeat mask shown
  // SHOW    | code of fault r_idx shown, r_rep frames already done
  // GAP     | one blank frame before the next code or return to idle

  localparam int unsigned PERIOD = period_cycles(FREQ_HZ, PERIOD_US);
  localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [TMR_W-1:0]     TMR_LAST  = TMR_W'(PERIOD - 1);
  localparam logic [REP_W-1:0]     REP_LAST  = REP_W'(REPEAT - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(N_FAULTS - 1);
  localparam logic [QUANT_CNT-1:0] MASK_IDLE = IDLE_MASK[QUANT_CNT-1:0];

  logic [TMR_W-1:0]     r_tmr;
  logic [N_FAULTS-1:0]  r_sticky;
  dgs_state_e           r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [REP_W-1:0]     r_rep;
  logic [QUANT_CNT-1:0] r_mask;
  logic                 r_active;
  logic [IDX_W-1:0]     r_cur_idx;

  logic                 w_tick;
  logic [IDX_W-1:0]     w_start;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_found;
  logic [QUANT_CNT-1:0] w_code;

  // Down-counter loaded with PERIOD-1 at reset: the terminal count lands on the same
  // cycle as an up-counter 0..PERIOD-1, keeping frames aligned with the blink driver.
  assign w_tick = (r_tmr == '0);

  // Starting the search at the last index makes idle pick the lowest set bit.
  assign w_start = (r_state == ST_GAP) ? r_idx : IDX_LAST;
  assign w_code  = QUANT_CNT'(code_mask(32'(w_pick_idx)));

  dgs_rr_pick #(
    .N     (N_FAULTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_vec   (r_sticky),
    .i_start (w_start),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tmr     <= TMR_LAST;
      r_sticky  <= '0;
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_rep     <= '0;
      r_mask    <= MASK_IDLE;
      r_active  <= 1'b0;
      r_cur_idx <= '0;
    end else begin
      r_sticky <= (i_clr ? '0 : r_sticky) | i_fault;
      r_tmr    <= w_tick ? TMR_LAST : r_tmr - 1'b1;
      if (w_tick) begin
        case (r_state)
          ST_SHOW: begin
            if ((r_rep < REP_LAST) && r_sticky[r_idx]) begin
              r_rep <= r_rep + 1'b1;
            end else begin
              r_state   <= ST_GAP;
              r_mask    <= '0;
              r_active  <= 1'b0;
              r_cur_idx <= '0;
            end
          end
          default: begin
            if (w_pick_found) begin
              r_state   <= ST_SHOW;
              r_idx     <= w_pick_idx;
              r_rep     <= '0;
              r_mask    <= w_code;
              r_active  <= 1'b1;
              r_cur_idx <= w_pick_idx;
            end else begin
              r_state   <= ST_IDLE;
              r_rep     <= '0;
              r_mask    <= MASK_IDLE;
              r_active  <= 1'b0;
              r_cur_idx <= '0;
            end
          end
        endcase
      end
    end
  end

  assign o_mask    = r_mask;
  assign o_active  = r_active;
  assign o_cur_idx = r_cur_idx;
  assign o_sticky  = r_sticky;

endmodule
